truth_table_sequencer: RTL
==========================

TRUTH_TABLE_SEQUENCER -- requirements
Module: truth_table_sequencer

Interface
REQ-001 The block SHALL have one clock; reset is asynchronous and active-high.
REQ-002 Parameter SETTLE, default 1, SHALL set the cycles each vector is held before sampling (legal 1..15).
REQ-003 Parameter EXP_Y1, default 16'h38F0, SHALL hold expected Y1 per index (bit n = vector n).
REQ-004 Parameter EXP_Y2, default 16'h0036, SHALL hold expected Y2 per index.
REQ-005 Ports SHALL be, in order:
  clk  in  1  rising-edge clock
  rst  in  1  async active-high reset
  start  in  1  begin a 16-vector scan (level sampled per cycle)
  abort  in  1  cancel scan in progress
  y1_i  in  1  Y1 from evaluated function block
  y2_i  in  1  Y2 from evaluated function block
  abcd_o  out  4  drive vector {A,B,C,D}, A = MSB
  busy  out  1  scan in progress
  done  out  1  scan complete, results valid
  pass  out  1  all 32 sampled bits matched expectation (valid while done)
  result_y1  out  16  captured Y1, bit n = vector n
  result_y2  out  16  captured Y2, bit n = vector n
  fail_cnt  out  5  number of vectors with any mismatch (0..16)
  first_fail  out  4  index of first mismatching vector; 0 when fail_cnt = 0

Function
REQ-006 FSM states SHALL be IDLE, DRIVE, SAMPLE, DONE.
REQ-007 IDLE or DONE with start=1 SHALL go to DRIVE next cycle with idx=0, settle counter=SETTLE, results/fail_cnt/first_fail/done/pass cleared.
REQ-008 abcd_o SHALL equal idx in DRIVE and SAMPLE, and 4'b0000 in IDLE.
REQ-009 abcd_o SHALL hold its last value (4'hF) in DONE.
REQ-010 DRIVE SHALL last exactly SETTLE cycles, then move to SAMPLE.
REQ-011 SAMPLE SHALL last one cycle; on its clock edge it SHALL write y1_i/y2_i into result bit idx.
REQ-012 On that same SAMPLE edge, if (y1_i != EXP_Y1[idx]) or (y2_i != EXP_Y2[idx]), fail_cnt SHALL increment by 1.
REQ-013 first_fail SHALL be loaded with idx only on the first such mismatch.
REQ-014 SAMPLE with idx<15 SHALL increment idx, reload the settle counter and return to DRIVE.
REQ-015 SAMPLE with idx=15 SHALL go to DONE without wrapping idx.
REQ-016 Scan latency from the start-accepting edge to done=1 SHALL be exactly 16*(SETTLE+1) cycles.
REQ-017 busy SHALL be 1 in DRIVE and SAMPLE, and 0 otherwise.
REQ-018 done SHALL be 1 only in DONE, held until the next start or abort.
REQ-019 pass SHALL equal (fail_cnt==0) in DONE, and 0 otherwise.
REQ-020 start while busy SHALL be ignored.
REQ-021 abort SHALL take priority over start and all transitions: next state IDLE, abcd_o=0, done=0, pass=0; results and fail_cnt keep partial values.
REQ-022 abort in IDLE SHALL have no effect; abort in DONE SHALL return to IDLE with done cleared.

Reset
REQ-023 rst=1 SHALL immediately force IDLE, idx=0, abcd_o=0, busy=0, done=0, pass=0, result_y1=0, result_y2=0, fail_cnt=0, first_fail=0.
REQ-024 Reset asserted mid-scan SHALL discard the scan; after deassertion no scan runs until a new start.

Structure
REQ-025 A shared package SHALL hold the FSM state encoding (2-bit), the default EXP_Y1/EXP_Y2 constants, and the vector count 16.
REQ-026 The bench SHALL provide one sub-module, minterm_eval: combinational Y1 = minterms {4,5,6,7,11,12,13} and Y2 = minterms {1,2,4,5} of {A,B,C,D}, driven by abcd_o and feeding y1_i/y2_i; the sequencer itself SHALL contain no copy of the function.

Verification
REQ-027 Scenario 1: SETTLE=1, minterm_eval connected, start pulsed one cycle -> done=1 exactly 32 cycles later; result_y1=16'h38F0, result_y2=16'h0036, fail_cnt=0, pass=1.
REQ-028 Scenario 2: y1_i forced 0 -> fail_cnt=7, first_fail=4, pass=0, result_y1=0.
REQ-029 Scenario 3: SETTLE=3 -> abcd_o holds each index for 3 cycles then 1 SAMPLE cycle; done after 64 cycles.
REQ-030 Scenario 4: abort asserted while abcd_o=6 -> IDLE next cycle; abcd_o=0, busy=0, done=0; result bits 0..5 retained.
REQ-031 Scenario 5: start held high for the whole scan -> single scan only, done=1 at cycle 32, then immediate restart from DONE with results cleared.
REQ-032 Scenario 6: rst pulsed asynchronously (mid-cycle) while idx=9 -> all outputs read zero before the next clock edge; IDLE after release.

Source files
------------

// File: rtl/truth_table_sequencer_pkg.sv
// Shared definitions for the truth-table sequencer: FSM encoding,
// default expected-response tables and the vector count.
package truth_table_sequencer_pkg;

    localparam int          NUM_VECTORS    = 16;
    localparam logic [15:0] DEFAULT_EXP_Y1 = 16'h38F0;
    localparam logic [15:0] DEFAULT_EXP_Y2 = 16'h0036;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DRIVE  = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } state_e;

    // True while a scan is stepping through the vectors.
    function automatic logic is_scanning(input state_e s);
        return (s == ST_DRIVE) || (s == ST_SAMPLE);
    endfunction

endpackage

// File: rtl/truth_table_sequencer_minterm_eval.sv
// Reference function block evaluated by the sequencer:
// Y1 = sum of minterms {4,5,6,7,11,12,13}, Y2 = sum of minterms {1,2,4,5}
// over the vector {A,B,C,D} with A as MSB.
module minterm_eval (
    input  logic [3:0] abcd_i,
    output logic       y1_o,
    output logic       y2_o
);

    // Pure combinational decode of the two minterm lists.
    always_comb begin
        y1_o = abcd_i inside {4'd4, 4'd5, 4'd6, 4'd7, 4'd11, 4'd12, 4'd13};
        y2_o = abcd_i inside {4'd1, 4'd2, 4'd4, 4'd5};
    end

endmodule

// File: rtl/truth_table_sequencer.sv
// Steps a 4-bit vector through all 16 input combinations, holds each for
// SETTLE cycles, samples the two responses and scores them against the
// expected tables. All outputs are registered.
module truth_table_sequencer
    import truth_table_sequencer_pkg::*;
#(
    parameter int          SETTLE = 1,
    parameter logic [15:0] EXP_Y1 = DEFAULT_EXP_Y1,
    parameter logic [15:0] EXP_Y2 = DEFAULT_EXP_Y2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        abort,
    input  logic        y1_i,
    input  logic        y2_i,
    output logic [3:0]  abcd_o,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [15:0] result_y1,
    output logic [15:0] result_y2,
    output logic [4:0]  fail_cnt,
    output logic [3:0]  first_fail
);

    localparam logic [3:0] SETTLE_CNT = 4'(SETTLE);
    localparam logic [3:0] LAST_IDX   = 4'(NUM_VECTORS - 1);

    state_e      state_q, state_d;
    logic [3:0]  idx_q, idx_d;
    logic [3:0]  settle_q, settle_d;
    logic [15:0] result_y1_q, result_y1_d;
    logic [15:0] result_y2_q, result_y2_d;
    logic [4:0]  fail_cnt_q, fail_cnt_d;
    logic [3:0]  first_fail_q, first_fail_d;
    logic [3:0]  abcd_q, abcd_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        pass_q, pass_d;
    logic        mismatch;

    assign mismatch = (y1_i != EXP_Y1[idx_q]) || (y2_i != EXP_Y2[idx_q]);

    // Next-state, scoring and registered-output computation.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
        state_d      = state_q;
        idx_d        = idx_q;
        settle_d     = settle_q;
        result_y1_d  = result_y1_q;
        result_y2_d  = result_y2_q;
        fail_cnt_d   = fail_cnt_q;
        first_fail_d = first_fail_q;

        if (abort) begin
            // Abort outranks start; partial results are kept for inspection.
            state_d = ST_IDLE;
        end else begin
            unique case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state_d      = ST_DRIVE;
                        idx_d        = 4'd0;
                        settle_d     = SETTLE_CNT;
                        result_y1_d  = 16'h0000;
                        result_y2_d  = 16'h0000;
                        fail_cnt_d   = 5'd0;
                        first_fail_d = 4'd0;
                    end
                end
                ST_DRIVE: begin
                    if (settle_q <= 4'd1) begin
                        state_d = ST_SAMPLE;
                    end else begin
                        settle_d = settle_q - 4'd1;
                    end
                end
                ST_SAMPLE: begin
                    result_y1_d[idx_q] = y1_i;
                    result_y2_d[idx_q] = y2_i;
                    if (mismatch) begin
                        fail_cnt_d = fail_cnt_q + 5'd1;
                        if (fail_cnt_q == 5'd0) begin
                            first_fail_d = idx_q;
                        end
                    end
                    if (idx_q == LAST_IDX) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d  = ST_DRIVE;
                        idx_d    = idx_q + 4'd1;
                        settle_d = SETTLE_CNT;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end

        // Outputs are derived from the next state so they register alongside it.
        abcd_d = (state_d == ST_IDLE) ? 4'd0 : idx_d;
        busy_d = is_scanning(state_d);
        done_d = (state_d == ST_DONE);
        pass_d = (state_d == ST_DONE) && (fail_cnt_d == 5'd0);
    end

    // Single state register for the FSM and all of its registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            state_q      <= ST_IDLE;
            idx_q        <= 4'd0;
            settle_q     <= 4'd0;
            result_y1_q  <= 16'h0000;
            result_y2_q  <= 16'h0000;
            fail_cnt_q   <= 5'd0;
            first_fail_q <= 4'd0;
            abcd_q       <= 4'd0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            settle_q     <= settle_d;
            result_y1_q  <= result_y1_d;
            result_y2_q  <= result_y2_d;
            fail_cnt_q   <= fail_cnt_d;
            first_fail_q <= first_fail_d;
            abcd_q       <= abcd_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            pass_q       <= pass_d;
        end
    end

    assign abcd_o     = abcd_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign pass       = pass_q;
    assign result_y1  = result_y1_q;
    assign result_y2  = result_y2_q;
    assign fail_cnt   = fail_cnt_q;
    assign first_fail = first_fail_q;

endmodule
